// File: rtl/md_pkg.sv
// md_pkg: shared op encodings, FSM states and helpers for the
// iterative multiply/divide unit (md_unit_iter).
package md_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  // widest operand the abs helper can take
  localparam int MD_MAXW = 128;

  typedef struct packed {
    logic is_div;
    logic is_signed;
  } md_dec_t;

  function automatic md_dec_t md_decode(
    input logic [1:0] op
  );
    md_dec_t d;
    d.is_div    = op[1];
    d.is_signed = ~op[0];
    return d;
  endfunction

  function automatic logic [MD_MAXW-1:0] abs_val(
    input logic [MD_MAXW-1:0] v,
    input logic               neg
  );
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/md_divstep.sv
// md_divstep: one combinational restoring-division step
// (shift in next dividend bit, trial subtract, quotient bit).
module md_divstep #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic            dbit,
  input  logic [XLEN-1:0] dvs,
  output logic [XLEN-1:0] rem_nx,
  output logic            q
);

  logic [XLEN:0] shifted;

  assign shifted = {rem, dbit};
  assign q       = (shifted >= {1'b0, dvs});
  assign rem_nx  = XLEN'(q ? shifted - {1'b0, dvs} : shifted);

endmodule

// File: rtl/md_unit_iter.sv
// md_unit_iter: iterative radix-2 mult/div unit with HI/LO registers.
// Optional MD_EARLY_OUT_EN: multiply finishes once multiplier bits run out.
module md_unit_iter
  import md_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            clrn,
  input  logic            md_start,
  input  logic [1:0]      md_op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            md_cancel,
  input  logic            mthi_we,
  input  logic            mtlo_we,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  logic [1:0]        state;
  logic [CNT_W-1:0]  count;
  logic              is_div;
  logic              neg_q;
  logic              neg_r;
  logic [XLEN-1:0]   opnd;
  logic [XLEN-1:0]   acc_hi;
  logic [XLEN-1:0]   acc_lo;

  md_dec_t           dec;
  logic              sa;
  logic              sb;
  logic [XLEN-1:0]   a_abs;
  logic [XLEN-1:0]   b_abs;
  logic [XLEN:0]     add_sum;
  logic [XLEN-1:0]   rem_nx;
  logic              q_bit;
  logic              mul_last;
  logic              start_fix;
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;

  assign dec   = md_decode(md_op);
  assign sa    = dec.is_signed & src_a[XLEN-1];
  assign sb    = dec.is_signed & src_b[XLEN-1];
  assign a_abs = XLEN'(abs_val(MD_MAXW'(src_a), sa));
  assign b_abs = XLEN'(abs_val(MD_MAXW'(src_b), sb));
  assign busy  = (state != IDLE);

  assign add_sum = {1'b0, acc_hi}
                 + (acc_lo[0] ? {1'b0, opnd} : '0);

  md_divstep #(.XLEN(XLEN)) u_divstep (
    .rem    (acc_hi),
    .dbit   (acc_lo[XLEN-1]),
    .dvs    (opnd),
    .rem_nx (rem_nx),
    .q      (q_bit)
  );

`ifdef MD_EARLY_OUT_EN
  logic [XLEN-1:0] left_mask;
  // low count-1 bits of acc_lo>>1 are the multiplier bits still pending
  assign left_mask = ~({XLEN{1'b1}} << (count - CNT_W'(1)));
  assign mul_last  = ~|((acc_lo >> 1) & left_mask);
  assign prod      = {acc_hi, acc_lo} >> count;
  assign start_fix = ~dec.is_div & (b_abs == '0);
`else
  assign mul_last  = (count == CNT_W'(1));
  assign prod      = {acc_hi, acc_lo};
  assign start_fix = 1'b0;
`endif

  assign prod_fix = neg_q ? ('0 - prod) : prod;
  assign quo_fix  = neg_q ? ('0 - acc_lo) : acc_lo;
  assign rem_fix  = neg_r ? ('0 - acc_hi) : acc_hi;

  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      state  <= IDLE;
      count  <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      opnd   <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (mthi_we) hi <= wdata;
          if (mtlo_we) lo <= wdata;
          if (md_start) begin
            state  <= start_fix ? FIX : CALC;
            count  <= CNT_W'(XLEN);
            is_div <= dec.is_div;
            // divide-by-zero keeps the raw all-ones quotient
            neg_q  <= (sa ^ sb) & ~(dec.is_div & (b_abs == '0));
            neg_r  <= dec.is_div & sa;
            opnd   <= dec.is_div ? b_abs : a_abs;
            acc_hi <= '0;
            acc_lo <= dec.is_div ? a_abs : b_abs;
          end
        end
        CALC: begin
          if (md_cancel) begin
            state <= IDLE;
          end else begin
            count <= count - CNT_W'(1);
            if (is_div) begin
              acc_hi <= rem_nx;
              acc_lo <= {acc_lo[XLEN-2:0], q_bit};
              if (count == CNT_W'(1)) state <= FIX;
            end else begin
              {acc_hi, acc_lo} <= {add_sum, acc_lo[XLEN-1:1]};
              if (mul_last) state <= FIX;
            end
          end
        end
        FIX: begin
          state <= IDLE;
          if (!md_cancel) begin
            done <= 1'b1;
            if (is_div) begin
              hi <= rem_fix;
              lo <= quo_fix;
            end else begin
              {hi, lo} <= prod_fix;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit_iter.sv
// tb_md_unit_iter: scoreboard bench for md_unit_iter (XLEN=32),
// arithmetic reference model plus directed and random operations.
module tb_md_unit_iter;

  logic        clk = 1'b0;
  logic        clrn = 1'b1;
  logic        md_start = 1'b0;
  logic [1:0]  md_op = 2'b00;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        md_cancel = 1'b0;
  logic        mthi_we = 1'b0;
  logic        mtlo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  md_unit_iter #(.XLEN(32)) dut (
    .clk       (clk),
    .clrn      (clrn),
    .md_start  (md_start),
    .md_op     (md_op),
    .src_a     (src_a),
    .src_b     (src_b),
    .md_cancel (md_cancel),
    .mthi_we   (mthi_we),
    .mtlo_we   (mtlo_we),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          at;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] mdl_hi = '0;
  logic [31:0] mdl_lo = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: every done pulse must match the oldest expectation
  always @(posedge clk) begin
    #1;
    if (done) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected none (cyc %0d)",
                 cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("res_hi", hi, e.hi);
        chk("res_lo", lo, e.lo);
        chk("latency", cyc, e.at);
      end
    end
  end

  function automatic int exp_lat(input logic [1:0] op, input logic [31:0] b);
    int lat;
    lat = 34;
`ifdef MD_EARLY_OUT_EN
    if (!op[1]) begin
      logic [31:0] babs;
      int idx;
      babs = (!op[0] && b[31]) ? -b : b;
      idx = -1;
      for (int i = 0; i < 32; i++) if (babs[i]) idx = i;
      lat = 2 + idx + 1;
    end
`endif
    return lat;
  endfunction

  task automatic model(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, output logic [31:0] rh,
                       output logic [31:0] rl);
    longint          sp;
    longint unsigned up;
    int              sa;
    int              sb;
    sa = a;
    sb = b;
    case (op)
      2'b00: begin
        sp = longint'(sa) * longint'(sb);
        {rh, rl} = sp;
      end
      2'b01: begin
        up = {32'b0, a} * {32'b0, b};
        {rh, rl} = up;
      end
      default: begin
        if (b == 0) begin
          rl = '1;
          rh = a;
        end else if (op == 2'b10 && a == 32'h8000_0000 && b == '1) begin
          rl = 32'h8000_0000;
          rh = '0;
        end else if (op == 2'b10) begin
          rl = sa / sb;
          rh = sa % sb;
        end else begin
          rl = a / b;
          rh = a % b;
        end
      end
    endcase
  endtask

  task automatic start_op(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit expect_done);
    exp_t e;
    @(negedge clk);
    md_op = op;
    src_a = a;
    src_b = b;
    md_start = 1'b1;
    if (expect_done) begin
      model(op, a, b, e.hi, e.lo);
      e.at = cyc + exp_lat(op, b);
      sb_q.push_back(e);
      mdl_hi = e.hi;
      mdl_lo = e.lo;
    end
    @(negedge clk);
    md_start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL timeout: busy still 1 after %0d cycles expected 0", n);
    end
  endtask

  task automatic do_op(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    start_op(op, a, b, 1'b1);
    wait_idle();
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'($urandom_range(0, 20));
      3: return 32'hFFFF_FFFF;
      4: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] prev_lo;
    int          cancel_at;
    repeat (3) @(negedge clk);
    clrn = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);

    do_op(2'b00, 32'hFFFF_FFFD, 32'd7);
    do_op(2'b01, 32'hFFFF_FFFF, 32'd2);
    do_op(2'b11, 32'd100, 32'd7);
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2);
    do_op(2'b11, 32'd5, 32'd0);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op(2'b10, 32'd7, 32'hFFFF_FFFE);
    do_op(2'b00, 32'd9, 32'd1);
    do_op(2'b00, 32'd9, 32'd0);
    do_op(2'b01, 32'd3, 32'd5);

    // mthi/mtlo in IDLE
    @(negedge clk);
    mthi_we = 1'b1;
    wdata = 32'h1234;
    @(negedge clk);
    mthi_we = 1'b0;
    chk("mthi", hi, 32'h1234);
    mthi_we = 1'b1;
    wdata = 32'hAA;
    @(negedge clk);
    mthi_we = 1'b0;
    mtlo_we = 1'b1;
    wdata = 32'hBB;
    @(negedge clk);
    mtlo_we = 1'b0;
    mdl_hi = 32'hAA;
    mdl_lo = 32'hBB;
    chk("mthi_aa", hi, mdl_hi);
    chk("mtlo_bb", lo, mdl_lo);

    // cancel in flight: no done, HI/LO kept
`ifdef MD_EARLY_OUT_EN
    cancel_at = 2;
`else
    cancel_at = 10;
`endif
    start_op(2'b00, 32'd6, 32'd7, 1'b0);
    repeat (cancel_at - 1) @(negedge clk);
    chk("busy_before_cancel", busy, 1);
    md_cancel = 1'b1;
    @(negedge clk);
    md_cancel = 1'b0;
    chk("cancel_busy", busy, 0);
    repeat (40) @(negedge clk);
    chk("cancel_hi", hi, mdl_hi);
    chk("cancel_lo", lo, mdl_lo);

    // start while busy is ignored
    start_op(2'b11, 32'd1000, 32'd3, 1'b1);
    repeat (4) @(negedge clk);
    md_op = 2'b00;
    src_a = 32'd9;
    src_b = 32'd9;
    md_start = 1'b1;
    @(negedge clk);
    md_start = 1'b0;
    wait_idle();
    repeat (5) @(negedge clk);

    // mtlo while busy is ignored
    prev_lo = mdl_lo;
    start_op(2'b11, 32'd100, 32'd7, 1'b1);
    repeat (2) @(negedge clk);
    mtlo_we = 1'b1;
    wdata = 32'h55;
    @(negedge clk);
    mtlo_we = 1'b0;
    chk("mtlo_busy", lo, prev_lo);
    wait_idle();

    // reset mid-operation
    start_op(2'b11, 32'd12345, 32'd17, 1'b0);
    repeat (19) @(negedge clk);
    clrn = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_hi", hi, 0);
    chk("midrst_lo", lo, 0);
    mdl_hi = '0;
    mdl_lo = '0;
    @(negedge clk);
    clrn = 1'b0;

    for (int i = 0; i < 40; i++) begin
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = 2'($urandom_range(0, 3));
      a = pick();
      b = pick();
      do_op(op, a, b);
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/md_unit_iter.md
Name: md_unit_iter

Overview:
- Parametrised iterative multiply/divide unit with architectural HI/LO registers for the Minisys1A pipeline EXE stage.
- Generalises the fixed 32-bit mult/div path to XLEN-bit operands.
- Provides a start/busy/done handshake for the hazard unit (MDPause/keepmd), a cancel input for pipeline flush, and mthi/mtlo writes.

Parameters:
- XLEN, 32, operand, HI and LO width; any even value ≥ 8.
- CNT_W, $clog2(XLEN)+1, iteration counter width.

Ports:
- clk  in  1  system clock, rising edge.
- clrn  in  1  reset; asynchronous, active-high.
- md_start  in  1  start request, sampled only in IDLE.
- md_op  in  2  00 mult, 01 multu, 10 div, 11 divu.
- src_a  in  XLEN  multiplicand / dividend (rs).
- src_b  in  XLEN  multiplier / divisor (rt).
- md_cancel  in  1  pipeline flush; aborts the operation in flight.
- mthi_we  in  1  write HI from wdata.
- mtlo_we  in  1  write LO from wdata.
- wdata  in  XLEN  mthi/mtlo data.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse when HI/LO are updated.
- hi  out  XLEN  HI register.
- lo  out  XLEN  LO register.

Behaviour:
- Reset: state=IDLE, busy=0, done=0, hi=0, lo=0, counter and operand latches 0.
- States:
  - IDLE: when md_start=1, latch |src_a|, |src_b|, result sign and remainder sign (signed ops only), set count=XLEN, go to CALC.
  - CALC: one radix-2 step per cycle. Multiply is shift-add, multiplier LSB first. Divide is restoring, quotient MSB first. count decrements each cycle; at count==1 go to FIX.
  - FIX: apply sign correction, write {hi,lo}, pulse done, go to IDLE.
- Timing: start sampled at edge 0; busy=1 after edge 0; HI/LO written and done=1 after edge XLEN+1; busy=0 after that same edge. Fixed latency is XLEN+2 cycles (34 for XLEN=32).
- Multiply result: full 2·XLEN product; hi = upper half, lo = lower half. Signed product is negated when the operand signs differ.
- Divide result: lo = quotient truncated toward zero; hi = remainder with the dividend's sign.
- Divide by zero (divisor 0): lo = all ones, hi = dividend unchanged. Detected at start; still takes the full latency.
- Signed overflow (div of -2^(XLEN-1) by -1): lo = -2^(XLEN-1), hi = 0.
- md_start while busy: ignored; no queueing.
- md_cancel while busy: go to IDLE next edge; HI/LO unchanged; no done pulse. Ignored in IDLE.
- md_cancel and FIX in the same cycle: cancel wins; no write.
- mthi_we/mtlo_we: take effect only in IDLE and are ignored while busy (the pipeline stalls them).
- mthi_we/mtlo_we together with md_start in IDLE: the move writes at that edge and the operation starts normally; the operation result later overwrites HI/LO.
- Reset asserted mid-operation: immediate return to reset values; no done pulse.

Optional Feature:
- Macro MD_EARLY_OUT_EN.
- Defined: a multiply in CALC whose remaining multiplier bits are all zero skips straight to FIX with the partial product shifted into alignment. Multiply latency becomes 2 + (index of highest set bit of |b| + 1), e.g. b=0 gives 2, b=1 gives 3, b=5 gives 5. Divide latency is unchanged.
- Undefined: every operation takes XLEN+2 cycles.

Decomposition:
- Shared package md_pkg holds:
  - op encodings MD_MULT, MD_MULTU, MD_DIV, MD_DIVU;
  - state enum IDLE/CALC/FIX;
  - helper function abs_val.
- Sub-module md_divstep: one combinational restoring-division step (partial remainder, divisor → next remainder, quotient bit), instantiated once inside CALC.

Test Plan (XLEN=32):
1. mult -3 × 7 → done exactly 34 cycles after start; hi=0xFFFFFFFF, lo=0xFFFFFFEB. multu 0xFFFFFFFF × 2 → hi=1, lo=0xFFFFFFFE.
2. divu 100 / 7 → lo=14, hi=2. div -7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
3. divu 5 / 0 → lo=0xFFFFFFFF, hi=5. div 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0. Both take 34 cycles.
4. Start mult 6 × 7 with hi/lo preset to 0xAA/0xBB; md_cancel at cycle 10 → busy=0 next cycle, no done, hi=0xAA, lo=0xBB. Also, md_start at cycle 5 of a busy op → ignored, single done.
5. mthi 0x1234 in IDLE → hi=0x1234 next edge. mtlo 0x55 while busy → lo unaffected until done writes the result.
6. Assert clrn at cycle 20 of a divu → hi=lo=0 and busy=0 immediately, no done. With MD_EARLY_OUT_EN: mult 9 × 1 → done after 3 cycles, lo=9.
